polinomio_mestre: RTL
=====================

Name: polinomio_mestre

Overview:
- Initiator side of the polynomial evaluator's start/ready handshake.
- Accepts coefficient jobs (X, A, B, C) from an upstream valid/ready source and drives them onto the evaluator's operand buses. Pulses `inicio`, waits for the evaluator's `done`, captures `Resultado`, then acknowledges with `pronto`.
- Completed results are buffered in a small FIFO for a downstream consumer. A watchdog flags evaluators that never finish.

Parameters:
- W, 16, operand/result width
- TIMEOUT, 64, max cycles in WAIT before declaring error (>=2)
- FIFO_DEPTH, 2, result FIFO entries (power of two, >=2)

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- job_valid  in  1  upstream job present
- job_ready  out  1  block accepts job this cycle
- job_X, job_A, job_B, job_C  in  W each  job operands
- inicio  out  1  start pulse to evaluator
- pronto  out  1  result-acknowledge pulse to evaluator
- X, A, B, C  out  W each  operands to evaluator, held stable for whole job
- done  in  1  evaluator result valid
- Resultado  in  W  evaluator result
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer pops head
- res_data  out  W  FIFO head result
- res_err  out  1  FIFO head entry is a timeout (res_data = 0)
- jobs_ok  out  16  count of successful jobs, wraps at 65535->0
- erro  out  1  sticky: any timeout since reset

Behaviour:
- Clock and reset: one clock `ck`; `rst` is asynchronous, active-high.
- Reset values:
  - state = IDLE; `inicio`, `pronto`, `erro` = 0.
  - X/A/B/C = 0; timer = 0; `jobs_ok` = 0.
  - FIFO empty, so `res_valid` = 0, `res_data` = 0, `res_err` = 0.
- Reset asserted mid-job drops the job; any `done` arriving afterward is ignored while in IDLE.
- States:
  - IDLE:
    - `job_ready` = 1 iff FIFO count < FIFO_DEPTH.
    - On `job_valid` & `job_ready`: latch the four operands into the X/A/B/C registers and go to START.
    - `job_ready` = 0 in every other state.
  - START:
    - `inicio` = 1 for exactly one cycle; clear timer; go to WAIT.
  - WAIT:
    - Timer increments each cycle.
    - If `done` = 1: push {err=0, Resultado}, increment `jobs_ok`, go to ACK.
    - Else if timer == TIMEOUT-1: push {err=1, 0}, set `erro`, go to ACK.
    - `done` and expiry in the same cycle: `done` wins.
  - ACK:
    - `pronto` = 1 for exactly one cycle; go to IDLE.
    - A new job can be accepted the cycle after ACK, so minimum job period = 4 + evaluator latency.
- Outputs `inicio` and `pronto` are registered, decoded from state; no combinational path from `done`.
- `done` outside WAIT is ignored.
- X/A/B/C change only on job acceptance in IDLE.
- FIFO:
  - One push per job; space is guaranteed because a job is accepted only when count < FIFO_DEPTH and at most one job is in flight.
  - Pop when `res_valid` & `res_ready`.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop with empty FIFO: no effect.
  - `res_data`/`res_err` reflect head combinationally from the FIFO storage; undefined content is masked to 0 when empty.
- Widths: operands and result are passed through unchanged (no arithmetic in this block); timer is ceil(log2(TIMEOUT)) bits.

Decomposition:
- Package polinomio_pkg:
  - state enum {IDLE, START, WAIT, ACK}
  - W default
  - TIMEOUT default
  - result-entry struct {err, data}
- One sub-module, fila_resultado: synchronous FIFO with parameters DEPTH and entry width.
  - Ports: push, push_data, pop, head_data, count, empty, full.

Test Plan:
- Single job: evaluator model computes A·X²+B·X+C with 5-cycle latency; X=2, A=3, B=4, C=5 -> `inicio` one cycle after acceptance, `res_data`=25, `res_err`=0, `pronto` one cycle after `done`, `jobs_ok`=1.
- Back-pressure: `res_ready`=0, issue 3 jobs (X=1..3, A=B=C=1) -> first two complete (results 3, 7); `job_ready` stays 0 after the second. Raise `res_ready` -> pops 3, 7; third job is accepted and yields 13.
- Timeout: evaluator never asserts `done`, TIMEOUT=64 -> exactly 64 cycles in WAIT, FIFO entry {err=1, 0}, `erro`=1 sticky, `pronto` pulsed, `jobs_ok` unchanged.
- Boundary: `done` on the final WAIT cycle (timer=63) -> treated as success, `erro` stays 0. Spurious `done` during IDLE -> no push.
- Simultaneous push/pop: FIFO holding one entry, `res_ready`=1 while a job completes -> count stays 1, head advances to the new result.
- Reset mid-job: assert `rst` during WAIT -> `inicio`/`pronto`=0 immediately, FIFO empty, `jobs_ok`=0. A later `done` has no effect. A new job after reset completes correctly.

Source files
------------

// File: rtl/polinomio_pkg.sv
// Shared types and defaults for the polynomial-evaluator initiator.
package polinomio_pkg;

  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

  typedef struct packed {
    logic             err;
    logic [W_DEF-1:0] data;
  } res_entry_t;

endpackage

// File: rtl/polinomio_mestre_fila_resultado.sv
// Synchronous result FIFO; the head is read combinationally and reads as zero when empty.
module fila_resultado #(
  parameter int DEPTH = 2,
  parameter int DW    = 17
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a push at full is still legal then.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/polinomio_mestre.sv
// Initiator for the polynomial evaluator: takes jobs, runs the inicio/done/pronto
// handshake with a watchdog, and queues results for a downstream consumer.
module polinomio_mestre
  import polinomio_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         ck,
  input  logic         rst,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [W-1:0] job_X,
  input  logic [W-1:0] job_A,
  input  logic [W-1:0] job_B,
  input  logic [W-1:0] job_C,
  output logic         inicio,
  output logic         pronto,
  output logic [W-1:0] X,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  input  logic         done,
  input  logic [W-1:0] Resultado,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic [15:0]  jobs_ok,
  output logic         erro
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic         err;
    logic [W-1:0] data;
  } entry_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic            expired, push, pop, empty, full;
  logic [CW-1:0]   count;
  entry_t          push_data, head;

  assign expired   = (timer == TW'(TIMEOUT - 1));
  assign push      = (state == WAIT) && (done || expired);
  assign job_ready = (state == IDLE) && (count < CW'(FIFO_DEPTH));
  assign res_valid = !empty;
  assign pop       = res_valid && res_ready;
  assign res_data  = head.data;
  assign res_err   = head.err;

  // done has priority over expiry when both land in the same cycle.
  always_comb begin
    push_data = '0;
    if (done) push_data = '{err: 1'b0, data: Resultado};
    else      push_data = '{err: 1'b1, data: '0};
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      inicio  <= 1'b0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
      X       <= '0;
      A       <= '0;
      B       <= '0;
      C       <= '0;
      timer   <= '0;
      jobs_ok <= '0;
    end else begin
      inicio <= 1'b0;
      pronto <= 1'b0;
      case (state)
        IDLE: if (job_valid && job_ready) begin
          X      <= job_X;
          A      <= job_A;
          B      <= job_B;
          C      <= job_C;
          inicio <= 1'b1;
          state  <= START;
        end
        START: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (done) begin
          jobs_ok <= jobs_ok + 16'd1;
          pronto  <= 1'b1;
          state   <= ACK;
        end else if (expired) begin
          erro   <= 1'b1;
          pronto <= 1'b1;
          state  <= ACK;
        end else begin
          timer <= timer + TW'(1);
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fila_resultado #(
    .DEPTH (FIFO_DEPTH),
    .DW    (W + 1)
  ) u_fila (
    .ck        (ck),
    .rst       (rst),
    .push      (push && !full),
    .push_data (push_data),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

endmodule
